// File: rtl/dsp_pkg.sv
// Shared widths and the elaboration-time legality check for the DSP input register stage.
package dsp_pkg;

  localparam int A_W      = 30;
  localparam int AMULT_W  = 25;
  localparam int B_W      = 18;
  localparam int INMODE_W = 5;

  // A cascade tap may not be deeper than its path, and a registered path must register its cascade.
  function automatic bit legal_depth(int depth, int casc);
    return (depth >= 0) && (depth <= 2) && (casc >= 0) && (casc <= depth) &&
           ((depth == 0) || (casc >= 1));
  endfunction

  function automatic bit legal_flag(int v);
    return (v == 0) || (v == 1);
  endfunction

endpackage

// File: rtl/dsp_pipe_reg2.sv
// Two-stage operand register with selectable depth 0/1/2; exposes stage 1 and the final value.
module dsp_pipe_reg2 #(
  parameter int DATA_W = 18,
  parameter int STAGES = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              srst_i,
  input  logic              ce1_i,
  input  logic              ce2_i,
  input  logic [DATA_W-1:0] d_i,
  output logic [DATA_W-1:0] s1_o,
  output logic [DATA_W-1:0] q_o
);

  if ((STAGES < 0) || (STAGES > 2)) begin : g_bad_stages
    $error("dsp_pipe_reg2: STAGES must be 0, 1 or 2");
  end

  logic [DATA_W-1:0] data_p1_q, data_p1_d;
  logic [DATA_W-1:0] data_p2_q, data_p2_d;

  // Stages outside the configured depth stay at zero and ignore their enables.
  always_comb begin
    data_p1_d = '0;
    data_p2_d = '0;
    if (STAGES == 2) begin
      data_p1_d = data_p1_q;
      if (srst_i)     data_p1_d = '0;
      else if (ce1_i) data_p1_d = d_i;
    end
    if (STAGES >= 1) begin
      data_p2_d = data_p2_q;
      if (srst_i)     data_p2_d = '0;
      else if (ce2_i) data_p2_d = (STAGES == 2) ? data_p1_q : d_i;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_p1_q <= '0;
      data_p2_q <= '0;
    end else begin
      data_p1_q <= data_p1_d;
      data_p2_q <= data_p2_d;
    end
  end

  assign s1_o = data_p1_q;
  assign q_o  = (STAGES == 0) ? d_i : data_p2_q;

endmodule

// File: rtl/ab_input_regs.sv
// DSP input register stage: selects A/B from fabric or cascade, pipelines them 0-2 deep,
// and drives pre-adder, multiplier, ALU and cascade operands plus the registered INMODE bus.
module ab_input_regs
  import dsp_pkg::*;
#(
  parameter int AREG        = 1,
  parameter int BREG        = 1,
  parameter int ACASCREG    = 1,
  parameter int BCASCREG    = 1,
  parameter int A_INPUT_SEL = 0,
  parameter int B_INPUT_SEL = 0,
  parameter int INMODEREG   = 1
) (
  input  logic                clk,
  input  logic                RST_N,
  input  logic                RSTA,
  input  logic                RSTB,
  input  logic                RSTINMODE,
  input  logic                CEA1,
  input  logic                CEA2,
  input  logic                CEB1,
  input  logic                CEB2,
  input  logic                CEINMODE,
  input  logic [A_W-1:0]      A,
  input  logic [A_W-1:0]      ACIN,
  input  logic [B_W-1:0]      B,
  input  logic [B_W-1:0]      BCIN,
  input  logic [INMODE_W-1:0] INMODE_IN,
  output logic [AMULT_W-1:0]  AMULT_REGA,
  output logic [A_W-1:0]      A_ALU,
  output logic [B_W-1:0]      BMULT,
  output logic [B_W-1:0]      B_ALU,
  output logic [A_W-1:0]      ACOUT,
  output logic [B_W-1:0]      BCOUT,
  output logic [INMODE_W-1:0] INMODE_OUT
);

  if (!legal_depth(AREG, ACASCREG)) begin : g_bad_a
    $error("ab_input_regs: illegal AREG/ACASCREG combination");
  end
  if (!legal_depth(BREG, BCASCREG)) begin : g_bad_b
    $error("ab_input_regs: illegal BREG/BCASCREG combination");
  end
  if (!legal_flag(A_INPUT_SEL) || !legal_flag(B_INPUT_SEL) || !legal_flag(INMODEREG)) begin : g_bad_flag
    $error("ab_input_regs: A_INPUT_SEL, B_INPUT_SEL and INMODEREG must be 0 or 1");
  end

  logic [A_W-1:0]      a_sel, a_s1, a_fin;
  logic [B_W-1:0]      b_sel, b_s1, b_fin;
  logic [INMODE_W-1:0] inmode_q, inmode_d;

  assign a_sel = (A_INPUT_SEL == 1) ? ACIN : A;
  assign b_sel = (B_INPUT_SEL == 1) ? BCIN : B;

  dsp_pipe_reg2 #(
    .DATA_W (A_W),
    .STAGES (AREG)
  ) u_a_pipe (
    .clk    (clk),
    .rst_n  (RST_N),
    .srst_i (RSTA),
    .ce1_i  (CEA1),
    .ce2_i  (CEA2),
    .d_i    (a_sel),
    .s1_o   (a_s1),
    .q_o    (a_fin)
  );

  dsp_pipe_reg2 #(
    .DATA_W (B_W),
    .STAGES (BREG)
  ) u_b_pipe (
    .clk    (clk),
    .rst_n  (RST_N),
    .srst_i (RSTB),
    .ce1_i  (CEB1),
    .ce2_i  (CEB2),
    .d_i    (b_sel),
    .s1_o   (b_s1),
    .q_o    (b_fin)
  );

  always_comb begin
    inmode_d = '0;
    if (INMODEREG == 1) begin
      inmode_d = inmode_q;
      if (RSTINMODE)     inmode_d = '0;
      else if (CEINMODE) inmode_d = INMODE_IN;
    end
  end

  always_ff @(posedge clk or negedge RST_N) begin
    if (!RST_N) inmode_q <= '0;
    else        inmode_q <= inmode_d;
  end

  assign INMODE_OUT = (INMODEREG == 1) ? inmode_q : INMODE_IN;

  assign A_ALU      = a_fin;
  assign AMULT_REGA = a_fin[AMULT_W-1:0];
  assign B_ALU      = b_fin;

  // A shallower cascade tap can only occur with a two-deep path, where it taps stage 1.
  assign ACOUT = (ACASCREG == AREG) ? a_fin : a_s1;
  assign BCOUT = (BCASCREG == BREG) ? b_fin : b_s1;

  // With two B stages, INMODE[4] lets the multiplier take the earlier B1 sample.
  assign BMULT = (BREG == 2) ? (INMODE_OUT[4] ? b_s1 : b_fin) : b_fin;

endmodule

// File: tb/tb_ab_input_regs.sv
// Bench for ab_input_regs: three configurations driven by shared stimulus and checked against a behavioural model.
module tb_ab_input_regs;

  localparam int NC = 3;
  localparam int AR  [NC] = '{2, 1, 0};
  localparam int AC  [NC] = '{1, 1, 0};
  localparam int BR  [NC] = '{2, 1, 0};
  localparam int BC  [NC] = '{1, 1, 0};
  localparam int ASL [NC] = '{0, 0, 1};
  localparam int BSL [NC] = '{0, 1, 1};
  localparam int IMR [NC] = '{1, 0, 0};

  logic clk = 1'b0;
  logic RST_N = 1'b0;
  logic RSTA = 1'b0, RSTB = 1'b0, RSTINMODE = 1'b0;
  logic CEA1 = 1'b1, CEA2 = 1'b1, CEB1 = 1'b1, CEB2 = 1'b1, CEINMODE = 1'b1;
  logic [29:0] A = '0, ACIN = '0;
  logic [17:0] B = '0, BCIN = '0;
  logic [4:0]  INMODE_IN = '0;

  logic [24:0] amult_o [NC];
  logic [29:0] a_alu_o [NC];
  logic [29:0] acout_o [NC];
  logic [17:0] bmult_o [NC];
  logic [17:0] b_alu_o [NC];
  logic [17:0] bcout_o [NC];
  logic [4:0]  inm_o   [NC];

  int vectors = 0;
  int miscompares = 0;
  bit chk_en = 1'b1;

  always #5 clk = ~clk;

  for (genvar g = 0; g < NC; g++) begin : g_dut
    ab_input_regs #(
      .AREG(AR[g]), .BREG(BR[g]), .ACASCREG(AC[g]), .BCASCREG(BC[g]),
      .A_INPUT_SEL(ASL[g]), .B_INPUT_SEL(BSL[g]), .INMODEREG(IMR[g])
    ) u_dut (
      .clk(clk), .RST_N(RST_N), .RSTA(RSTA), .RSTB(RSTB), .RSTINMODE(RSTINMODE),
      .CEA1(CEA1), .CEA2(CEA2), .CEB1(CEB1), .CEB2(CEB2), .CEINMODE(CEINMODE),
      .A(A), .ACIN(ACIN), .B(B), .BCIN(BCIN), .INMODE_IN(INMODE_IN),
      .AMULT_REGA(amult_o[g]), .A_ALU(a_alu_o[g]), .BMULT(bmult_o[g]), .B_ALU(b_alu_o[g]),
      .ACOUT(acout_o[g]), .BCOUT(bcout_o[g]), .INMODE_OUT(inm_o[g])
    );
  end

  task automatic check(input string nm, input int c, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s dut%0d: got 0x%0h expected 0x%0h at %0t", nm, c, act, exp, $time);
    end
  endtask

  // Behavioural model: the contents of each configured stage per configuration.
  logic [29:0] ma1 [NC] = '{default: '0};
  logic [29:0] ma2 [NC] = '{default: '0};
  logic [17:0] mb1 [NC] = '{default: '0};
  logic [17:0] mb2 [NC] = '{default: '0};
  logic [4:0]  mim [NC] = '{default: '0};

  always @(posedge clk or negedge RST_N) begin
    logic [29:0] asel, na1, na2;
    logic [17:0] bsel, nb1, nb2;
    if (!RST_N) begin
      for (int c = 0; c < NC; c++) begin
        ma1[c] = '0; ma2[c] = '0; mb1[c] = '0; mb2[c] = '0; mim[c] = '0;
      end
    end else begin
      for (int c = 0; c < NC; c++) begin
        asel = (ASL[c] == 1) ? ACIN : A;
        bsel = (BSL[c] == 1) ? BCIN : B;
        na1 = '0; na2 = '0; nb1 = '0; nb2 = '0;
        if (AR[c] == 2) begin
          na1 = RSTA ? '0 : (CEA1 ? asel : ma1[c]);
          na2 = RSTA ? '0 : (CEA2 ? ma1[c] : ma2[c]);
        end else if (AR[c] == 1) begin
          na2 = RSTA ? '0 : (CEA2 ? asel : ma2[c]);
        end
        if (BR[c] == 2) begin
          nb1 = RSTB ? '0 : (CEB1 ? bsel : mb1[c]);
          nb2 = RSTB ? '0 : (CEB2 ? mb1[c] : mb2[c]);
        end else if (BR[c] == 1) begin
          nb2 = RSTB ? '0 : (CEB2 ? bsel : mb2[c]);
        end
        ma1[c] = na1; ma2[c] = na2; mb1[c] = nb1; mb2[c] = nb2;
        if (IMR[c] == 1) mim[c] = RSTINMODE ? '0 : (CEINMODE ? INMODE_IN : mim[c]);
      end
    end
  end

  always @(negedge clk) begin
    logic [29:0] afin, acexp;
    logic [17:0] bfin, bcexp, bmexp;
    logic [4:0]  imexp;
    if (chk_en) begin
      for (int c = 0; c < NC; c++) begin
        afin  = (AR[c] == 0) ? ((ASL[c] == 1) ? ACIN : A) : ma2[c];
        bfin  = (BR[c] == 0) ? ((BSL[c] == 1) ? BCIN : B) : mb2[c];
        acexp = (AC[c] == AR[c]) ? afin : ma1[c];
        bcexp = (BC[c] == BR[c]) ? bfin : mb1[c];
        imexp = (IMR[c] == 1) ? mim[c] : INMODE_IN;
        bmexp = (BR[c] == 2) ? (imexp[4] ? mb1[c] : mb2[c]) : bfin;
        check("amult", c, 32'(amult_o[c]), 32'(afin[24:0]));
        check("a_alu", c, 32'(a_alu_o[c]), 32'(afin));
        check("acout", c, 32'(acout_o[c]), 32'(acexp));
        check("b_alu", c, 32'(b_alu_o[c]), 32'(bfin));
        check("bcout", c, 32'(bcout_o[c]), 32'(bcexp));
        check("bmult", c, 32'(bmult_o[c]), 32'(bmexp));
        check("inmode", c, 32'(inm_o[c]), 32'(imexp));
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic at_neg();
    @(negedge clk);
    #1;
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #2 RST_N = 1'b1;
    at_neg();
    check("rst_release", 0, 32'(a_alu_o[0]), 32'h0);
    check("rst_release_im", 0, 32'(inm_o[0]), 32'h0);

    // Async reset mid-operation with A2 full of ones.
    A = 30'h3FFFFFFF;
    step(); step(); step();
    at_neg();
    check("a2_full", 0, 32'(a_alu_o[0]), 32'h3FFFFFFF);
    check("a2_full", 1, 32'(a_alu_o[1]), 32'h3FFFFFFF);
    #1 RST_N = 1'b0;
    #1;
    check("async_rst_a", 0, 32'(a_alu_o[0]), 32'h0);
    check("async_rst_ac", 0, 32'(acout_o[0]), 32'h0);
    check("async_rst_am", 1, 32'(amult_o[1]), 32'h0);
    step();
    RST_N = 1'b1;
    at_neg();
    check("post_rst_hold", 0, 32'(a_alu_o[0]), 32'h0);
    check("post_rst_hold", 1, 32'(a_alu_o[1]), 32'h0);
    step();
    at_neg();
    check("first_load", 1, 32'(a_alu_o[1]), 32'h3FFFFFFF);
    check("first_load_d2", 0, 32'(a_alu_o[0]), 32'h0);

    // AREG=2, ACASCREG=1 sequence.
    A = 30'h1; step(); at_neg();
    check("seq_acout1", 0, 32'(acout_o[0]), 32'h1);
    A = 30'h2; step(); at_neg();
    check("seq_acout2", 0, 32'(acout_o[0]), 32'h2);
    check("seq_amult1", 0, 32'(amult_o[0]), 32'h1);
    A = 30'h3; step(); at_neg();
    check("seq_acout3", 0, 32'(acout_o[0]), 32'h3);
    check("seq_amult2", 0, 32'(amult_o[0]), 32'h2);
    A = 30'h0; step(); at_neg();
    check("seq_amult3", 0, 32'(amult_o[0]), 32'h3);

    // Cascade input selection on B.
    BCIN = 18'h2AAAA; B = 18'h15555; step(); at_neg();
    check("bcin_sel", 1, 32'(bmult_o[1]), 32'h2AAAA);

    // BMULT selection between B1 and B2 via registered INMODE[4].
    INMODE_IN = 5'h00; B = 18'h00022; CEB1 = 1'b1; CEB2 = 1'b0; step();
    B = 18'h00011; CEB2 = 1'b1; step();
    CEB1 = 1'b0; CEB2 = 1'b0; at_neg();
    check("bmult_b2", 0, 32'(bmult_o[0]), 32'h22);
    INMODE_IN = 5'h10; step(); at_neg();
    check("bmult_b1", 0, 32'(bmult_o[0]), 32'h11);
    INMODE_IN = 5'h00; step(); at_neg();
    check("bmult_b2_again", 0, 32'(bmult_o[0]), 32'h22);
    CEB1 = 1'b1; CEB2 = 1'b1;

    // CE hold on the single A stage.
    A = 30'h100; step(); at_neg();
    check("ce_load", 1, 32'(amult_o[1]), 32'h100);
    CEA2 = 1'b0;
    for (int i = 0; i < 3; i++) begin
      A = 30'h200 + 30'(i); step(); at_neg();
      check("ce_hold", 1, 32'(amult_o[1]), 32'h100);
    end
    CEA2 = 1'b1; A = 30'h777; step(); at_neg();
    check("ce_release", 1, 32'(amult_o[1]), 32'h777);

    // Sync reset beats CE; RSTINMODE clears the INMODE register.
    RSTA = 1'b1; A = 30'h1234567; step(); at_neg();
    check("rsta_wins", 1, 32'(a_alu_o[1]), 32'h0);
    check("rsta_wins", 0, 32'(a_alu_o[0]), 32'h0);
    check("rsta_a1", 0, 32'(acout_o[0]), 32'h0);
    RSTA = 1'b0;
    INMODE_IN = 5'h1F; step(); at_neg();
    check("inmode_load", 0, 32'(inm_o[0]), 32'h1F);
    RSTINMODE = 1'b1; step(); at_neg();
    check("rstinmode", 0, 32'(inm_o[0]), 32'h0);
    RSTINMODE = 1'b0;

    // Randomised traffic; the compare process checks every cycle.
    for (int i = 0; i < 400; i++) begin
      A = 30'($urandom); ACIN = 30'($urandom);
      B = 18'($urandom); BCIN = 18'($urandom);
      INMODE_IN = 5'($urandom);
      CEA1 = ($urandom_range(0, 3) != 0); CEA2 = ($urandom_range(0, 3) != 0);
      CEB1 = ($urandom_range(0, 3) != 0); CEB2 = ($urandom_range(0, 3) != 0);
      CEINMODE = ($urandom_range(0, 3) != 0);
      RSTA = ($urandom_range(0, 15) == 0); RSTB = ($urandom_range(0, 15) == 0);
      RSTINMODE = ($urandom_range(0, 15) == 0);
      RST_N = ($urandom_range(0, 63) != 0);
      step();
    end
    RST_N = 1'b1;
    at_neg();
    chk_en = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/ab_input_regs.md
# ab_input_regs

Input register stage of the DSP slice. It sits directly upstream of the pre-adder and multiplier. It selects the A and B operands from the fabric or from the cascade inputs, and passes them through 0, 1 or 2 pipeline stages. It drives the pre-adder A operand, the multiplier B operand, the A/B cascade outputs and the registered INMODE bus.

## Interface
- AREG, 1: A pipeline depth (0, 1, 2).
- BREG, 1: B pipeline depth (0, 1, 2).
- ACASCREG, 1: depth seen on ACOUT. Must be ≤ AREG, and ≥1 when AREG≥1; otherwise elaboration error.
- BCASCREG, 1: same rule against BREG.
- A_INPUT_SEL, 0: 0 = A port, 1 = ACIN.
- B_INPUT_SEL, 0: 0 = B port, 1 = BCIN.
- INMODEREG, 1: INMODE register present (0, 1).
- clk  in  1  Clock; all registers rise-edge.
- RST_N  in  1  Reset, asynchronous, active-low; clears every register to 0.
- RSTA  in  1  Synchronous reset, A1/A2.
- RSTB  in  1  Synchronous reset, B1/B2.
- RSTINMODE  in  1  Synchronous reset, INMODE register.
- CEA1, CEA2  in  1 each  Clock enables, A1/A2.
- CEB1, CEB2  in  1 each  Clock enables, B1/B2.
- CEINMODE  in  1  Clock enable, INMODE register.
- A, ACIN  in  30 each  Fabric / cascade A.
- B, BCIN  in  18 each  Fabric / cascade B.
- INMODE_IN  in  5  Fabric INMODE.
- AMULT_REGA  out  25  Final A[24:0], to pre-adder.
- A_ALU  out  30  Final A, full width, for A:B concatenation.
- BMULT  out  18  Multiplier B operand.
- B_ALU  out  18  Final B.
- ACOUT  out  30  A cascade out.
- BCOUT  out  18  B cascade out.
- INMODE_OUT  out  5  INMODE to downstream; [3:0] to pre-adder, [4] used here.

## Operation
- a_sel = A_INPUT_SEL ? ACIN : A. b_sel is built the same way from B/BCIN.
- A1: loads a_sel when CEA1.
- A2: loads (AREG==2 ? A1 : a_sel) when CEA2.
- A_final:
  - AREG=0: a_sel, combinational.
  - AREG≥1: A2.
- B path is identical, with B1/B2, CEB1/CEB2 and BREG.
- Unused registers for the configured depth are held at 0 and ignore their CE.
- ACOUT:
  - ACASCREG==AREG: A_final.
  - AREG=2 and ACASCREG=1: A1.
- BCOUT follows the same rule.
- AMULT_REGA = A_final[24:0]; A_ALU = A_final; B_ALU = B_final.
- BMULT:
  - BREG=2: INMODE_OUT[4] ? B1 : B2.
  - Otherwise: B_final.
- INMODE_OUT:
  - INMODEREG=1: register loaded from INMODE_IN when CEINMODE.
  - INMODEREG=0: INMODE_IN passed through.
- Priority per register: RST_N low (async) > sync reset > CE > hold.

## Timing
- Reset: every output is 0 during and after RST_N low. Exception: with depth 0, the output follows its combinational input.
- RST_N deassertion is synchronous to clk externally. The first load occurs on the first rising edge with RST_N high.
- Latency from a_sel to A_final is AREG cycles, with CEs held high. B follows the same rule with BREG.
- Latency from INMODE_IN to INMODE_OUT is INMODEREG cycles.
- CE low freezes a stage. The other stage keeps loading per its own CE, so A2 may capture a stale A1.
- Sync reset and CE high on the same edge: the register becomes 0.
- RSTA clears A1 and A2 on the same edge. RSTB clears B1 and B2 on the same edge.
- Cascade-select changes take effect on the next load, with no extra latency.

## Structure
- Shared package dsp_pkg holds:
  - width constants A_W=30, AMULT_W=25, B_W=18, INMODE_W=5;
  - the legal-depth check function used by the elaboration assertions.
- One natural sub-module, dsp_pipe_reg2. It is a parameterised-width two-stage register with depth 0/1/2, CE1/CE2, sync reset and async RST_N, and it exposes stage-1 and final outputs.
- Instantiate dsp_pipe_reg2 for the A and B paths.
- The INMODE register is a single inline stage.

## Test plan
- Async reset: drive RST_N=0 mid-operation with A2=0x3FFFFFFF. All outputs read 0 immediately, without a clock edge. Release RST_N; outputs stay 0 until the first loaded edge.
- AREG=2, ACASCREG=1: apply A=0x0000001, 0x0000002, 0x0000003 on consecutive cycles with all CEs high.
  - ACOUT reads 1, 2, 3, starting one cycle after the first value was applied.
  - AMULT_REGA reads 1, 2, 3, starting two cycles after.
- B_INPUT_SEL=1, BREG=1: BCIN=0x2AAAA, B=0x15555. After one edge, BMULT=0x2AAAA.
- BREG=2 with B1=0x00011 and B2=0x00022:
  - INMODE_IN[4]=1 and INMODEREG=1: BMULT=0x00011 one cycle after INMODE_IN changes.
  - INMODE_IN[4]=0: BMULT=0x00022.
- CE hold: with AREG=1, hold CEA2=0 for 3 cycles while A changes. AMULT_REGA holds its prior value. Raise CEA2: it updates on the next edge.
- RSTA=1 and CEA2=1 on the same edge with A=0x1234567: A2 becomes 0. RSTINMODE clears INMODE_OUT to 0 on its edge.
